// File: rtl/divide_pkg.sv
// ---------------------------------------------------------------------------
// divide_pkg
// Shared definitions for the sequential restoring divider (seq_divide).
//   state_t : FSM state encoding (S_IDLE=0, S_CALC=1, S_DONE=2)
//   clog2   : width of a counter that must hold values 0..value-1
// No ports (package).
// ---------------------------------------------------------------------------
package divide_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // Ceiling log2, clamped to at least 1 so a counter never ends up zero bits wide.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < value) begin
            result = i + 1;
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// fa_cell
// One-bit full adder used to build the trial subtractor.
//   a, b, ci : addend bits and carry in
//   s, co    : sum and carry out
//
// div_step
// One restoring division step, purely combinational.
//   r_in  [WIDTH:0]   partial remainder before the step
//   q_in  [WIDTH-1:0] partial quotient / remaining dividend bits
//   d_in  [WIDTH-1:0] divisor
//   r_out [WIDTH:0]   partial remainder after the step
//   q_out [WIDTH-1:0] partial quotient after the step
// The pair {R,Q} is shifted left by one, then D is trial-subtracted from R
// with a WIDTH+1-bit ripple chain of fa_cell instances (R + ~D + 1). A carry
// out of the chain means no borrow, so the difference is kept and a 1 enters
// the quotient; otherwise the shifted remainder is restored.
// ---------------------------------------------------------------------------
module fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module div_step #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0]   r_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH:0]   r_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   r_shift;
   logic [WIDTH:0]   d_inv;
   logic [WIDTH:0]   diff;
   logic [WIDTH+1:0] carry;
   logic             no_borrow;
   logic             unused_r_msb;

   // R stays below D between steps, so its top bit is always zero and is
   // simply shifted out; the shifted value still needs all WIDTH+1 bits.
   assign unused_r_msb = r_in[WIDTH];
   assign r_shift      = {r_in[WIDTH-1:0], q_in[WIDTH-1]};
   assign d_inv        = ~{1'b0, d_in};
   assign carry[0]     = 1'b1;

   for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
      fa_cell u_fa (
         .a  (r_shift[i]),
         .b  (d_inv[i]),
         .ci (carry[i]),
         .s  (diff[i]),
         .co (carry[i+1])
      );
   end

   assign no_borrow = carry[WIDTH+1];
   assign r_out     = no_borrow ? diff : r_shift;
   assign q_out     = {q_in[WIDTH-2:0], no_borrow};

endmodule

// File: rtl/seq_divide.sv
// ---------------------------------------------------------------------------
// seq_divide
// Sequential restoring divider: 2*WIDTH-bit unsigned dividend by WIDTH-bit
// unsigned divisor, one quotient bit per clock, valid/ready on both sides.
//   clk, rst            clock, synchronous active-high reset
//   in_valid / in_ready input handshake (in_ready only in IDLE)
//   dividend, divisor   operands, latched on in_valid & in_ready
//   out_valid/out_ready output handshake (out_valid only in DONE)
//   quotient, remainder result, held stable while out_ready is low
//   div0, ovf           error flags, present only when DIVIDE_FLAGS_EN is defined
// Divide-by-zero and quotient overflow are detected at accept time and go
// straight to DONE with a saturated quotient, whether or not the flag ports
// are built.
// ---------------------------------------------------------------------------
module seq_divide
   import divide_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [2*WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0]   divisor,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder
`ifdef DIVIDE_FLAGS_EN
   ,
   output logic               div0,
   output logic               ovf
`endif
);

   localparam int CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] d_q, d_d;
   logic [WIDTH:0]   step_r;
   logic [WIDTH-1:0] step_q;
   logic             accept;
   logic             is_div0;
   logic             is_ovf;

   assign accept  = in_valid && (state_q == S_IDLE);
   assign is_div0 = (divisor == '0);
   // With a zero divisor this compare is always true, hence the explicit
   // exclusion so div0 wins over ovf.
   assign is_ovf  = !is_div0 && (dividend[2*WIDTH-1:WIDTH] >= divisor);

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .r_in  (r_q),
      .q_in  (q_q),
      .d_in  (d_q),
      .r_out (step_r),
      .q_out (step_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: error operations skip CALC entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (is_div0 || is_ovf) ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            if (cnt_q == LAST_STEP) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      in_ready  = (state_q == S_IDLE);
      out_valid = (state_q == S_DONE);
      quotient  = q_q;
      remainder = r_q[WIDTH-1:0];
   end

   // Datapath next values: load on accept, one restoring step per CALC cycle,
   // hold otherwise so the result stays stable under backpressure.
   always_comb begin
      cnt_d = cnt_q;
      r_d   = r_q;
      q_d   = q_q;
      d_d   = d_q;
      if (accept) begin
         d_d   = divisor;
         cnt_d = '0;
         if (is_div0) begin
            q_d = '1;
            r_d = {1'b0, dividend[WIDTH-1:0]};
         end else if (is_ovf) begin
            q_d = '1;
            r_d = '0;
         end else begin
            r_d = {1'b0, dividend[2*WIDTH-1:WIDTH]};
            q_d = dividend[WIDTH-1:0];
         end
      end else if (state_q == S_CALC) begin
         r_d   = step_r;
         q_d   = step_q;
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         r_q   <= '0;
         q_q   <= '0;
         d_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         r_q   <= r_d;
         q_q   <= q_d;
         d_q   <= d_d;
      end
   end

`ifdef DIVIDE_FLAGS_EN
   logic div0_q, div0_d;
   logic ovf_q, ovf_d;

   // Flags are captured at accept and dropped as the result is handed off.
   always_comb begin
      div0_d = div0_q;
      ovf_d  = ovf_q;
      if (accept) begin
         div0_d = is_div0;
         ovf_d  = is_ovf;
      end else if ((state_q == S_DONE) && out_ready) begin
         div0_d = 1'b0;
         ovf_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div0_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         div0_q <= div0_d;
         ovf_q  <= ovf_d;
      end
   end

   assign div0 = div0_q;
   assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_divide.sv
// ---------------------------------------------------------------------------
// tb_seq_divide
// Self-checking bench for seq_divide (WIDTH=8): a table of directed vectors,
// randomized operations against an arithmetic reference model, and
// hand-written sequences for backpressure and reset during CALC.
// Flag checks are compiled in when DIVIDE_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_seq_divide;

   localparam int WIDTH = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] dividend;
   logic [WIDTH-1:0]   divisor;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;
`ifdef DIVIDE_FLAGS_EN
   logic               div0;
   logic               ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] dvd;
      logic [7:0]  dvs;
      logic [7:0]  q;
      logic [7:0]  r;
      int          lat;
      logic        f_div0;
      logic        f_ovf;
   } vec_t;

   vec_t vecs[7];

   seq_divide #(
      .WIDTH (WIDTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder)
`ifdef DIVIDE_FLAGS_EN
      ,
      .div0      (div0),
      .ovf       (ovf)
`endif
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Single comparison; every check in the bench funnels through here.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference model straight from the arithmetic definition of the divider.
   function automatic void refModel(input logic [15:0] dvd, input logic [7:0] dvs,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output int lat, output logic f_div0,
                                    output logic f_ovf);
      int n, d;
      n = int'(dvd);
      d = int'(dvs);
      f_div0 = 1'b0;
      f_ovf  = 1'b0;
      if (d == 0) begin
         q = 8'hFF;
         r = dvd[7:0];
         lat = 1;
         f_div0 = 1'b1;
      end else if (n / d > 255) begin
         q = 8'hFF;
         r = 8'h00;
         lat = 1;
         f_ovf = 1'b1;
      end else begin
         q = 8'(n / d);
         r = 8'(n % d);
         lat = WIDTH + 1;
      end
   endfunction

   // Issue one operation from IDLE, measure latency from the accept edge,
   // capture the result, then hand it off with out_ready.
   task automatic applyStimulus(input logic [15:0] dvd, input logic [7:0] dvs,
                                output logic [7:0] got_q, output logic [7:0] got_r,
                                output int lat, output logic got_div0,
                                output logic got_ovf);
      checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
      dividend = dvd;
      divisor  = dvs;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      if (!out_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL out_valid_timeout: got 0 after %0d cycles, expected 1", lat);
      end
      got_q = quotient;
      got_r = remainder;
`ifdef DIVIDE_FLAGS_EN
      got_div0 = div0;
      got_ovf  = ovf;
`else
      got_div0 = 1'b0;
      got_ovf  = 1'b0;
`endif
      checkOutput("in_ready_done", 32'(in_ready), 32'd0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("out_valid_after_handoff", 32'(out_valid), 32'd0);
   endtask

   task automatic runAndCompare(input string tag, input vec_t v);
      logic [7:0] gq, gr;
      int         glat;
      logic       gd0, gov;
      applyStimulus(v.dvd, v.dvs, gq, gr, glat, gd0, gov);
      checkOutput({tag, "_quotient"}, 32'(gq), 32'(v.q));
      checkOutput({tag, "_remainder"}, 32'(gr), 32'(v.r));
      checkOutput({tag, "_latency"}, 32'(glat), 32'(v.lat));
`ifdef DIVIDE_FLAGS_EN
      checkOutput({tag, "_div0"}, 32'(gd0), 32'(v.f_div0));
      checkOutput({tag, "_ovf"}, 32'(gov), 32'(v.f_ovf));
`endif
   endtask

   initial begin
      vec_t v;
      int   stray;

      vecs[0] = '{16'd65025, 8'd255, 8'd255, 8'd0,   9, 1'b0, 1'b0};
      vecs[1] = '{16'd1000,  8'd7,   8'd142, 8'd6,   9, 1'b0, 1'b0};
      vecs[2] = '{16'd3600,  8'd240, 8'd15,  8'd0,   9, 1'b0, 1'b0};
      vecs[3] = '{16'h1234,  8'h00,  8'hFF,  8'h34,  1, 1'b1, 1'b0};
      vecs[4] = '{16'h1000,  8'h10,  8'hFF,  8'h00,  1, 1'b0, 1'b1};
      vecs[5] = '{16'h0FFF,  8'h10,  8'hFF,  8'h0F,  9, 1'b0, 1'b0};
      vecs[6] = '{16'd100,   8'd9,   8'd11,  8'd1,   9, 1'b0, 1'b0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_quotient", 32'(quotient), 32'd0);
      checkOutput("reset_remainder", 32'(remainder), 32'd0);
`ifdef DIVIDE_FLAGS_EN
      checkOutput("reset_div0", 32'(div0), 32'd0);
      checkOutput("reset_ovf", 32'(ovf), 32'd0);
`endif
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] directed vectors");
      for (int i = 0; i < 7; i++) begin
         runAndCompare($sformatf("vec%0d", i), vecs[i]);
      end

      $display("[TB] randomized operations");
      for (int i = 0; i < 60; i++) begin
         v.dvs = 8'($urandom_range(0, 255));
         if (v.dvs != 0 && $urandom_range(0, 3) != 0) begin
            v.dvd = {8'($urandom_range(0, int'(v.dvs) - 1)), 8'($urandom_range(0, 255))};
         end else begin
            v.dvd = 16'($urandom_range(0, 65535));
         end
         refModel(v.dvd, v.dvs, v.q, v.r, v.lat, v.f_div0, v.f_ovf);
         runAndCompare($sformatf("rand%0d", i), v);
      end

      $display("[TB] backpressure in DONE");
      dividend = 16'd1000;
      divisor  = 8'd7;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      for (int k = 0; k < 40 && !out_valid; k++) begin
         @(posedge clk);
         #1;
      end
      checkOutput("bp_out_valid_reached", 32'(out_valid), 32'd1);
      for (int k = 0; k < 5; k++) begin
         in_valid = (k == 1 || k == 2);
         if (k == 1) begin
            dividend = 16'd50;
            divisor  = 8'd3;
         end
         @(posedge clk);
         #1;
         checkOutput($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
         checkOutput($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
         checkOutput($sformatf("bp%0d_quotient", k), 32'(quotient), 32'd142);
         checkOutput($sformatf("bp%0d_remainder", k), 32'(remainder), 32'd6);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput("bp_release_in_ready", 32'(in_ready), 32'd1);
      checkOutput("bp_release_out_valid", 32'(out_valid), 32'd0);
      stray = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) stray++;
      end
      checkOutput("bp_second_op_not_taken", 32'(stray), 32'd0);

      $display("[TB] reset during CALC");
      dividend = 16'd65025;
      divisor  = 8'd255;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("midcalc_busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("midcalc_rst_in_ready", 32'(in_ready), 32'd1);
      checkOutput("midcalc_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("midcalc_rst_quotient", 32'(quotient), 32'd0);
      stray = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) stray++;
      end
      checkOutput("midcalc_result_discarded", 32'(stray), 32'd0);
      runAndCompare("after_rst", vecs[6]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
